// File: rtl/countdown_timer.sv
// Tenths-of-a-second countdown timer with start/stop and load buttons.
// Outputs use the stopwatch tenth_sec/sec format and a sticky expired flag.
module countdown_timer #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       st_n,
  input  logic       load_n,
  input  logic [5:0] preset_sec,
  input  logic [3:0] preset_tenth,
  output logic [3:0] tenth_sec,
  output logic [5:0] sec,
  output logic       running,
  output logic       expired
);

  // DIV must be an exact quotient and at least 2.
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAUSED  = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0] btn_n;
  logic [1:0] press;
  logic       start_p;
  logic       load_p;

  assign btn_n = {load_n, st_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic s1_q, s2_q, s3_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s1_q <= 1'b1;
          s2_q <= 1'b1;
          s3_q <= 1'b1;
        end else begin
          s1_q <= btn_n[gi];
          s2_q <= s1_q;
          s3_q <= s2_q;
        end
      end

      assign press[gi] = s3_q & ~s2_q;
    end
  endgenerate

  assign start_p = press[0];
  assign load_p  = press[1];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [3:0]    tenth_q, tenth_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic [5:0]    load_sec;
  logic [3:0]    load_tenth;

  assign load_sec   = (preset_sec > 6'd59)  ? 6'd59 : preset_sec;
  assign load_tenth = (preset_tenth > 4'd9) ? 4'd9  : preset_tenth;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    sec_d     = sec_q;
    tenth_d   = tenth_q;
    running_d = running_q;
    expired_d = expired_q;
    if (state_q == ST_RUN) begin
      // In RUN a start press wins over both load and a coincident tick.
      if (start_p) begin
        state_d   = ST_PAUSED;
        running_d = 1'b0;
      end else if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (tenth_q != 4'd0) begin
          tenth_d = tenth_q - 4'd1;
        end else begin
          tenth_d = 4'd9;
          sec_d   = sec_q - 6'd1;
        end
        if (sec_q == 6'd0 && tenth_q == 4'd1) begin
          state_d   = ST_EXPIRED;
          expired_d = 1'b1;
          running_d = 1'b0;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (load_p) begin
      sec_d     = load_sec;
      tenth_d   = load_tenth;
      presc_d   = '0;
      expired_d = 1'b0;
      running_d = 1'b0;
      state_d   = (load_sec != 6'd0 || load_tenth != 4'd0) ? ST_PAUSED : ST_IDLE;
    end else if (start_p) begin
      if (state_q == ST_PAUSED) begin
        state_d   = ST_RUN;
        presc_d   = '0;
        running_d = 1'b1;
      end else if (state_q == ST_EXPIRED) begin
        state_d   = ST_IDLE;
        expired_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      sec_q     <= 6'd0;
      tenth_q   <= 4'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      tenth_q   <= tenth_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign tenth_sec = tenth_q;
  assign sec       = sec_q;
  assign running   = running_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and random stimulus for countdown_timer, checked each cycle against
// a model that keeps the time as a single count of tenths.
module tb_countdown_timer;

  localparam int CLKF = 20;
  localparam int TKHZ = 10;
  localparam int DIV  = CLKF / TKHZ;

  localparam int M_IDLE = 0, M_PAUSED = 1, M_RUN = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       st_n = 1'b1;
  logic       load_n = 1'b1;
  logic [5:0] preset_sec = 6'd0;
  logic [3:0] preset_tenth = 4'd0;
  logic [3:0] tenth_sec;
  logic [5:0] sec;
  logic       running;
  logic       expired;

  countdown_timer #(.CLK_FREQ_HZ(CLKF), .TICK_HZ(TKHZ)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .st_n         (st_n),
    .load_n       (load_n),
    .preset_sec   (preset_sec),
    .preset_tenth (preset_tenth),
    .tenth_sec    (tenth_sec),
    .sec          (sec),
    .running      (running),
    .expired      (expired)
  );

  always #5 clk = ~clk;

  int    n_assert = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  // Reference model: time held as total tenths; button history as pin samples.
  int m_total, m_state, m_cnt;
  bit m_exp;
  bit sh1, sh2, sh3, lh1, lh2, lh3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_state = M_IDLE; m_cnt = 0; m_exp = 0;
    sh1 = 1; sh2 = 1; sh3 = 1; lh1 = 1; lh2 = 1; lh3 = 1;
  endtask

  task automatic model_step();
    bit sp, lp;
    int s, t;
    if (!rstn) begin
      model_reset();
      return;
    end
    sp = !sh2 && sh3;
    lp = !lh2 && lh3;
    if (m_state == M_RUN) begin
      if (sp) m_state = M_PAUSED;
      else if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_total = m_total - 1;
        if (m_total == 0) begin
          m_state = M_EXP;
          m_exp = 1;
        end
      end else m_cnt++;
    end else if (lp) begin
      s = (int'(preset_sec) > 59) ? 59 : int'(preset_sec);
      t = (int'(preset_tenth) > 9) ? 9 : int'(preset_tenth);
      m_total = s * 10 + t;
      m_cnt = 0;
      m_exp = 0;
      m_state = (m_total != 0) ? M_PAUSED : M_IDLE;
    end else if (sp) begin
      if (m_state == M_PAUSED) begin
        m_state = M_RUN;
        m_cnt = 0;
      end else if (m_state == M_EXP) begin
        m_state = M_IDLE;
        m_exp = 0;
      end
    end
    sh3 = sh2; sh2 = sh1; sh1 = st_n;
    lh3 = lh2; lh2 = lh1; lh1 = load_n;
  endtask

  task automatic check_all();
    chk("sec", 32'(sec), 32'(m_total / 10));
    chk("tenth", 32'(tenth_sec), 32'(m_total % 10));
    chk("running", 32'(running), 32'(m_state == M_RUN));
    chk("expired", 32'(expired), 32'(m_exp));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic press(input bit s, input bit l);
    if (s) st_n = 1'b0;
    if (l) load_n = 1'b0;
    step(1);
    st_n = 1'b1;
    load_n = 1'b1;
    step(3);
  endtask

  task automatic load_val(input int s, input int t);
    preset_sec = 6'(s);
    preset_tenth = 4'(t);
    press(0, 1);
  endtask

  task automatic wait_expired(input int budget);
    int i = 0;
    while (expired !== 1'b1 && i < budget) begin
      step(1);
      i++;
    end
    chk("expired_within_budget", 32'(expired), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("rst_sec", 32'(sec), 32'd0);
    chk("rst_tenth", 32'(tenth_sec), 32'd0);
    rstn = 1'b1;
    step(2);

    phase = "load_expire";
    load_val(0, 3);
    chk("loaded_tenth", 32'(tenth_sec), 32'd3);
    chk("loaded_running", 32'(running), 32'd0);
    press(1, 0);
    wait_expired(20);
    chk("exp_running", 32'(running), 32'd0);
    chk("exp_tenth", 32'(tenth_sec), 32'd0);
    step(10);
    chk("hold_tenth", 32'(tenth_sec), 32'd0);
    chk("hold_sec", 32'(sec), 32'd0);

    phase = "borrow";
    load_val(1, 0);
    chk("ld_sec", 32'(sec), 32'd1);
    chk("ld_expired", 32'(expired), 32'd0);
    press(1, 0);
    for (int i = 0; i < 10 && tenth_sec !== 4'd9; i++) step(1);
    chk("borrow_sec", 32'(sec), 32'd0);
    chk("borrow_tenth", 32'(tenth_sec), 32'd9);
    wait_expired(30);
    step(4);
    chk("nowrap_sec", 32'(sec), 32'd0);
    chk("nowrap_tenth", 32'(tenth_sec), 32'd0);

    phase = "clamp";
    load_val(63, 15);
    chk("clamp_sec", 32'(sec), 32'd59);
    chk("clamp_tenth", 32'(tenth_sec), 32'd9);
    chk("clamp_running", 32'(running), 32'd0);

    phase = "pause";
    load_val(2, 0);
    st_n = 1'b0;
    step(1);
    st_n = 1'b1;
    load_n = 1'b0;
    preset_sec = 6'd5;
    preset_tenth = 4'd5;
    step(1);
    load_n = 1'b1;
    step(1);
    st_n = 1'b0;
    step(1);
    st_n = 1'b1;
    step(10);
    chk("frozen_sec", 32'(sec), 32'd1);
    chk("frozen_tenth", 32'(tenth_sec), 32'd9);
    chk("frozen_running", 32'(running), 32'd0);
    press(1, 0);
    step(1);
    chk("resume_tenth", 32'(tenth_sec), 32'd8);
    chk("resume_running", 32'(running), 32'd1);

    phase = "simul_B";
    press(1, 1);
    chk("B_running", 32'(running), 32'd0);
    step(4);
    phase = "simul_A";
    preset_sec = 6'd4;
    preset_tenth = 4'd4;
    press(1, 1);
    chk("A_sec", 32'(sec), 32'd4);
    chk("A_tenth", 32'(tenth_sec), 32'd4);
    chk("A_running", 32'(running), 32'd0);

    phase = "exp_clear";
    load_val(0, 2);
    press(1, 0);
    wait_expired(20);
    press(1, 0);
    chk("clr_expired", 32'(expired), 32'd0);
    chk("clr_running", 32'(running), 32'd0);
    press(1, 0);
    chk("ign_running", 32'(running), 32'd0);
    chk("ign_tenth", 32'(tenth_sec), 32'd0);

    phase = "async_reset";
    load_val(3, 0);
    press(1, 0);
    step(5);
    #2 rstn = 1'b0;
    #1;
    chk("ar_sec", 32'(sec), 32'd0);
    chk("ar_tenth", 32'(tenth_sec), 32'd0);
    chk("ar_running", 32'(running), 32'd0);
    chk("ar_expired", 32'(expired), 32'd0);
    model_reset();
    step(1);
    rstn = 1'b1;
    step(2);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        preset_sec = 6'($urandom_range(0, 63));
        preset_tenth = 4'($urandom_range(0, 15));
      end
      st_n = ($urandom_range(0, 11) != 0);
      load_n = ($urandom_range(0, 19) != 0);
      rstn = ($urandom_range(0, 399) != 0);
      step(1);
    end
    rstn = 1'b1;
    st_n = 1'b1;
    load_n = 1'b1;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
